// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-master, one-slave arbiter for the data-memory request/response bus
// between the pipeline memory stage (master 0) and the dcache (slave).
// Master 1 is a secondary requester such as a debug or DMA port.
//
// Master 0 has fixed priority. A wait counter bounds how long master 1 can
// be refused: once it reaches MAX_WAIT, master 1 wins the next arbitration.
// While the slave stalls a granted access, the grant is locked to that
// master so the slave always sees a stable request.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   m0_* / m1_*       per-master request (addr, rd, wr, wdata, be) and
//                     response (rdata, hold, rvalid)
//   s_*               slave request (addr, rd, wr, wdata, be) and
//                     response (rdata, hold)
//
// Parameters:
//   MAX_WAIT          refusals tolerated for master 1 (1..255)
//   CNT_W             wait counter width, must be able to hold MAX_WAIT

module dmem_arbiter #(
    parameter int MAX_WAIT = 7,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_addr,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic [31:0] m0_rdata,
    output logic        m0_hold,
    output logic        m0_rvalid,

    input  logic [31:0] m1_addr,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic [31:0] m1_rdata,
    output logic        m1_hold,
    output logic        m1_rvalid,

    output logic [31:0] s_addr,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    input  logic [31:0] s_rdata,
    input  logic        s_hold
);

    // Lock state: which master, if any, owns the slave across a stall.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_M0   = 2'd1,
        LOCK_M1   = 2'd2
    } lock_state_t;

    lock_state_t      lock_state;
    lock_state_t      lock_next;
    logic             lock_valid;
    logic             lock_id;

    logic             req0;
    logic             req1;
    logic             grant_valid;
    logic             grant_id;
    logic             granted_req;
    logic             acc;
    logic             acc1;
    logic             wait_full;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       rvalid_q;

    assign req0       = m0_rd | m0_wr;
    assign req1       = m1_rd | m1_wr;
    assign lock_valid = (lock_state != LOCK_NONE);
    assign lock_id    = (lock_state == LOCK_M1);
    assign wait_full  = (wait_cnt == CNT_W'(MAX_WAIT));

    // Same-cycle arbitration. A lock wins outright, even if its owner has
    // dropped the request; otherwise master 0 wins unless master 1 has
    // waited long enough or master 0 is idle.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (lock_valid) begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
        end else if (req1 && (!req0 || wait_full)) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end
    end

    // Slave request mux. With no grant the data path idles on master 0 and
    // both strobes are forced low.
    always_comb begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_be    = m0_be;
        s_rd    = 1'b0;
        s_wr    = 1'b0;
        if (grant_valid && grant_id) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_be    = m1_be;
        end
        if (grant_valid) begin
            s_rd = grant_id ? m1_rd : m0_rd;
            s_wr = grant_id ? m1_wr : m0_wr;
        end
    end

    assign granted_req = grant_valid & (grant_id ? req1 : req0);
    assign acc         = granted_req & ~s_hold;
    assign acc1        = acc & grant_id;

    // The core freezes on any slave stall, so s_hold reaches master 0 even
    // when it is idle. Master 1 only stalls while it has a request.
    assign m0_hold = s_hold | (req0 & ~(grant_valid & ~grant_id));
    assign m1_hold = req1 & (s_hold | ~(grant_valid & grant_id));

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= LOCK_NONE;
        end else begin
            lock_state <= lock_next;
        end
    end

    // Any cycle the slave accepts releases the lock; a stalled request from
    // the granted master captures it. A stall without a granted request
    // leaves the lock unchanged.
    always_comb begin
        lock_next = lock_state;
        if (!s_hold) begin
            lock_next = LOCK_NONE;
        end else if (granted_req) begin
            lock_next = grant_id ? LOCK_M1 : LOCK_M0;
        end
    end

    // Master 1 starvation counter, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req1 || acc1) begin
            wait_cnt <= '0;
        end else if (!wait_full) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Read-valid pulses. A stalled return cycle keeps its pending flag so
    // the pulse appears once the slave releases s_hold with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 2'b00;
        end else if (!s_hold) begin
            rvalid_q <= {acc & grant_id & m1_rd, acc & ~grant_id & m0_rd};
        end
    end

    assign m0_rvalid = rvalid_q[0] & ~s_hold;
    assign m1_rvalid = rvalid_q[1] & ~s_hold;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Testbench for dmem_arbiter: directed cycle table followed by randomized
// traffic compared against a transaction-level reference model.

module tb_dmem_arbiter;

    localparam int MAX_WAIT = 7;
    localparam logic [31:0] WD0 = 32'hA5A5_A5A5;
    localparam logic [31:0] WD1 = 32'h5A5A_5A5A;
    localparam logic [3:0]  BE0 = 4'hC;
    localparam logic [3:0]  BE1 = 4'hF;
    localparam logic [31:0] A1  = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_rd, m0_wr, m0_hold, m0_rvalid;
    logic [3:0]  m0_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_rd, m1_wr, m1_hold, m1_rvalid;
    logic [3:0]  m1_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_rd, s_wr, s_hold;
    logic [3:0]  s_be;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_rdata(m0_rdata), .m0_hold(m0_hold), .m0_rvalid(m0_rvalid),
        .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_rdata(m1_rdata), .m1_hold(m1_hold), .m1_rvalid(m1_rvalid),
        .s_addr(s_addr), .s_rd(s_rd), .s_wr(s_wr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_hold(s_hold)
    );

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;

    // Per-master stimulus, indexed by master number.
    logic        rdA[2];
    logic        wrA[2];
    logic [31:0] addrA[2];
    logic [31:0] wdA[2];
    logic [3:0]  beA[2];
    logic        shIn;
    logic        rstIn;
    logic [31:0] rdataIn;

    // Reference model state: lock owner (-1 none), refusals seen by master 1,
    // and reads accepted whose data has not yet been handed back.
    int  lockOwner = -1;
    int  waited    = 0;
    bit  pend[2]   = '{0, 0};
    bit  lastAcc[2] = '{0, 0};

    typedef struct {
        logic        rst;
        logic        m0rd, m0wr;
        logic [31:0] a0;
        logic        m1rd, m1wr;
        logic        sh;
        logic [31:0] rdata;
        logic        eSrd, eSwr, eSel1, eH0, eH1, eRv0, eRv1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic m0rd, logic m0wr, logic [31:0] a0,
                                logic m1rd, logic m1wr, logic sh, logic [31:0] rd,
                                logic esrd, logic eswr, logic esel, logic eh0,
                                logic eh1, logic erv0, logic erv1);
        vec_t v;
        v.rst = r; v.m0rd = m0rd; v.m0wr = m0wr; v.a0 = a0;
        v.m1rd = m1rd; v.m1wr = m1wr; v.sh = sh; v.rdata = rd;
        v.eSrd = esrd; v.eSwr = eswr; v.eSel1 = esel; v.eH0 = eh0;
        v.eH1 = eh1; v.eRv0 = erv0; v.eRv1 = erv1;
        return v;
    endfunction

    task automatic applyStimulus();
        rst      = rstIn;
        m0_rd    = rdA[0];  m0_wr    = wrA[0];  m0_addr = addrA[0];
        m0_wdata = wdA[0];  m0_be    = beA[0];
        m1_rd    = rdA[1];  m1_wr    = wrA[1];  m1_addr = addrA[1];
        m1_wdata = wdA[1];  m1_be    = beA[1];
        s_hold   = shIn;
        s_rdata  = rdataIn;
        for (int n = 0; n < 2; n++)
            if (rdA[n] && wrA[n])
                $display("[TB] warning: master %0d drives rd and wr together", n);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycleNo, act, exp);
        end
    endtask

    // Whose turn it is, from the arbitration rules.
    function automatic int modelGrant();
        bit r0, r1;
        r0 = rdA[0] | wrA[0];
        r1 = rdA[1] | wrA[1];
        if (lockOwner >= 0) return lockOwner;
        if (r1 && (!r0 || waited >= MAX_WAIT)) return 1;
        if (r0) return 0;
        return -1;
    endfunction

    task automatic checkModel();
        int g;
        int sel;
        bit r0, r1;
        g   = modelGrant();
        sel = (g == 1) ? 1 : 0;
        r0  = rdA[0] | wrA[0];
        r1  = rdA[1] | wrA[1];
        checkOutput("s_addr",  s_addr,  addrA[sel]);
        checkOutput("s_wdata", s_wdata, wdA[sel]);
        checkOutput("s_be",    {28'd0, s_be}, {28'd0, beA[sel]});
        checkOutput("s_rd",    {31'd0, s_rd}, {31'd0, (g >= 0) ? rdA[g] : 1'b0});
        checkOutput("s_wr",    {31'd0, s_wr}, {31'd0, (g >= 0) ? wrA[g] : 1'b0});
        checkOutput("m0_hold", {31'd0, m0_hold}, {31'd0, shIn | (r0 && g != 0)});
        checkOutput("m1_hold", {31'd0, m1_hold}, {31'd0, r1 && (shIn || g != 1)});
        checkOutput("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, pend[0] && !shIn});
        checkOutput("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, pend[1] && !shIn});
        checkOutput("m0_rdata", m0_rdata, rdataIn);
        checkOutput("m1_rdata", m1_rdata, rdataIn);
    endtask

    task automatic updateModel();
        int g;
        bit acc[2];
        g = modelGrant();
        for (int n = 0; n < 2; n++)
            acc[n] = (g == n) && (rdA[n] | wrA[n]) && !shIn;
        if (rstIn) begin
            lockOwner = -1;
            waited    = 0;
            pend      = '{0, 0};
            acc       = '{0, 0};
        end else begin
            if (!shIn) lockOwner = -1;
            else if (g >= 0 && (rdA[g] | wrA[g])) lockOwner = g;
            if (!(rdA[1] | wrA[1]) || acc[1]) waited = 0;
            else if (waited < MAX_WAIT) waited++;
            if (!shIn)
                for (int n = 0; n < 2; n++) pend[n] = acc[n] && rdA[n];
        end
        lastAcc = acc;
    endtask

    // A master keeps its request until it is accepted, then picks a new one.
    task automatic genStimulus(input bit fresh);
        int r;
        for (int n = 0; n < 2; n++) begin
            if (fresh || lastAcc[n] || !(rdA[n] | wrA[n])) begin
                r = $urandom_range(0, 9);
                rdA[n]   = (r >= ((n == 0) ? 2 : 5)) && (r < 8);
                wrA[n]   = (r >= 8);
                addrA[n] = $urandom & 32'hFFFF_FFFC;
                wdA[n]   = $urandom;
                beA[n]   = 4'($urandom_range(1, 15));
            end
        end
        shIn    = ($urandom_range(0, 9) < 3);
        rdataIn = $urandom;
        rstIn   = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        // Directed cycle table. Master 1 always targets A1; eSel1 marks
        // cycles where the slave data path must come from master 1.
        vecs.push_back(mk(0,1,0,32'h100,0,0,0,32'h0,        1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h100,0,0,0,32'hDEADBEEF, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,0,32'h100,0,1,0,32'h0,        1,0,0,0,1,0,0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,1,0,32'h100,0,1,0,32'h0,    1,0,0,0,1,1,0));
        vecs.push_back(mk(0,1,0,32'h100,0,1,0,32'h0,        0,1,1,1,0,1,0));
        vecs.push_back(mk(0,1,0,32'h100,0,1,0,32'h0,        1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,32'h100,0,0,0,32'h0,        0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,32'h100,1,0,1,32'h0,        1,0,1,1,1,0,0));
        vecs.push_back(mk(0,1,0,32'h100,1,0,1,32'h0,        1,0,1,1,1,0,0));
        vecs.push_back(mk(0,1,0,32'h100,1,0,1,32'h0,        1,0,1,1,1,0,0));
        vecs.push_back(mk(0,1,0,32'h100,1,0,0,32'h0,        1,0,1,1,0,0,0));
        vecs.push_back(mk(0,1,0,32'h100,0,0,0,32'h12345678, 1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h100,0,0,0,32'h0,        0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,32'h100,0,0,1,32'h0,        0,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,32'h100,0,0,0,32'h0,        0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h100,1,0,1,32'h0,        1,0,1,1,1,0,0));
        vecs.push_back(mk(1,0,0,32'h100,1,0,1,32'h0,        1,0,1,1,1,0,0));
        vecs.push_back(mk(0,1,0,32'h100,1,0,0,32'h0,        1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,32'h100,0,0,0,32'h0,        0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,0,32'h0,  0,0,0,32'h0,        1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h4,  0,0,1,32'hCAFEF00D, 1,0,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,32'h4,  0,0,0,32'hCAFEF00D, 1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,32'h4,  0,0,0,32'h0BADF00D, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,32'h4,  0,0,0,32'h0,        0,0,0,0,0,0,0));

        rdA = '{0, 0}; wrA = '{0, 0};
        addrA = '{32'h0, A1}; wdA = '{WD0, WD1}; beA = '{BE0, BE1};
        shIn = 1'b0; rdataIn = 32'h0; rstIn = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        checkOutput("reset_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        checkOutput("reset_s_rd",      {31'd0, s_rd},      32'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            cycleNo = i;
            rstIn = vecs[i].rst;  shIn = vecs[i].sh;  rdataIn = vecs[i].rdata;
            rdA[0] = vecs[i].m0rd; wrA[0] = vecs[i].m0wr; addrA[0] = vecs[i].a0;
            rdA[1] = vecs[i].m1rd; wrA[1] = vecs[i].m1wr; addrA[1] = A1;
            applyStimulus();
            #1;
            checkOutput("tbl_s_rd",  {31'd0, s_rd},  {31'd0, vecs[i].eSrd});
            checkOutput("tbl_s_wr",  {31'd0, s_wr},  {31'd0, vecs[i].eSwr});
            checkOutput("tbl_s_addr", s_addr, vecs[i].eSel1 ? A1 : vecs[i].a0);
            checkOutput("tbl_s_wdata", s_wdata, vecs[i].eSel1 ? WD1 : WD0);
            checkOutput("tbl_s_be", {28'd0, s_be}, {28'd0, vecs[i].eSel1 ? BE1 : BE0});
            checkOutput("tbl_m0_hold", {31'd0, m0_hold}, {31'd0, vecs[i].eH0});
            checkOutput("tbl_m1_hold", {31'd0, m1_hold}, {31'd0, vecs[i].eH1});
            checkOutput("tbl_m0_rvalid", {31'd0, m0_rvalid}, {31'd0, vecs[i].eRv0});
            checkOutput("tbl_m1_rvalid", {31'd0, m1_rvalid}, {31'd0, vecs[i].eRv1});
            checkOutput("tbl_m0_rdata", m0_rdata, vecs[i].rdata);
            checkOutput("tbl_m1_rdata", m1_rdata, vecs[i].rdata);
            @(negedge clk);
        end

        // Randomized traffic, starting with a reset so the model and the
        // design begin from the same state.
        genStimulus(1'b1);
        rstIn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cycleNo = 1000 + c;
            applyStimulus();
            #1;
            checkModel();
            updateModel();
            @(negedge clk);
            genStimulus(rstIn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
